// File: rtl/life_sequencer.sv
// Generation controller for an 8x8 Game of Life board: scans all 64 cells through the
// next-state engine, collects results into a shadow board and commits them atomically.
// Optional macro LIFE_SEQ_STABLE_DETECT_EN: flag a still life and stop auto-advance.
module life_sequencer #(
   parameter int          GEN_TICKS  = 12000000,
   parameter logic [63:0] INIT_BOARD = 64'h0000_0000_0007_0402
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        step,
   input  logic        load_valid,
   input  logic [63:0] load_board,
   input  logic        cell_next,
   output logic [63:0] board,
   output logic [2:0]  read_cell_row,
   output logic [2:0]  read_cell_col,
   output logic        curr_cell,
   output logic        write_board_state,
   output logic        busy,
   output logic        gen_done,
   output logic [15:0] generation,
   output logic        stable
);

   localparam int TICK_W = (GEN_TICKS > 1) ? $clog2(GEN_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [5:0]        idx;
   logic [63:0]       shadow;
   logic [TICK_W-1:0] tick;
   logic              tick_hit;
   logic              auto_block;
   logic              start_scan;

   assign tick_hit = (tick == TICK_W'(GEN_TICKS - 1));

   // Cell handshake: the engine answers combinationally for the addressed cell on every
   // cycle write_board_state is high; there is no back-pressure, one cell per cycle.
   // idx is held at 0 outside SCAN, so the address rests on row 0 col 0.
   assign read_cell_row     = idx[5:3];
   assign read_cell_col     = idx[2:0];
   assign curr_cell         = board[idx];
   assign write_board_state = (state == SCAN);
   assign busy              = (state != IDLE);
   assign gen_done          = (state == COMMIT) && !load_valid;

   always_comb begin
      state_next = state;
      start_scan = 1'b0;
      case (state)
         IDLE: begin
            if (step || (run && tick_hit && !auto_block)) begin
               state_next = SCAN;
               start_scan = 1'b1;
            end
         end
         SCAN: begin
            if (idx == 6'd63) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         board      <= INIT_BOARD;
         shadow     <= '0;
         tick       <= '0;
         idx        <= '0;
         generation <= '0;
      end else if (load_valid) begin
         // A load aborts any scan in flight; the partial shadow is simply abandoned.
         state      <= IDLE;
         board      <= load_board;
         tick       <= '0;
         idx        <= '0;
         generation <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start_scan) begin
                  tick   <= '0;
                  idx    <= '0;
                  shadow <= '0;
               end else if (run) begin
                  tick <= tick_hit ? '0 : tick + TICK_W'(1);
               end else begin
                  tick <= '0;
               end
            end
            SCAN: begin
               shadow[idx] <= cell_next;
               idx         <= idx + 6'd1;
            end
            COMMIT: begin
               board      <= shadow;
               generation <= generation + 16'd1;
            end
            default: begin
               tick <= '0;
            end
         endcase
      end
   end

`ifdef LIFE_SEQ_STABLE_DETECT_EN
   logic stable_q;

   always_ff @(posedge clk) begin
      if (rst || load_valid) begin
         stable_q <= 1'b0;
      end else if (state == COMMIT) begin
         stable_q <= (shadow == board);
      end
   end

   assign stable     = stable_q;
   assign auto_block = stable_q;
`else
   assign stable     = 1'b0;
   assign auto_block = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Directed-sequence bench for life_sequencer with random boards checked against a
// whole-board Game of Life reference model.
module tb_life_sequencer;

   localparam int          GT   = 4;
   localparam logic [63:0] INIT = 64'h0000_0000_0007_0402;
`ifdef LIFE_SEQ_STABLE_DETECT_EN
   localparam logic STAB = 1'b1;
`else
   localparam logic STAB = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        run;
   logic        step;
   logic        load_valid;
   logic [63:0] load_board;
   logic        cell_next;
   logic [63:0] board;
   logic [2:0]  read_cell_row;
   logic [2:0]  read_cell_col;
   logic        curr_cell;
   logic        write_board_state;
   logic        busy;
   logic        gen_done;
   logic [15:0] generation;
   logic        stable;

   int          n_checks;
   int          n_pass;
   logic [63:0] exp_board;
   logic [15:0] exp_gen;
   logic [63:0] eng_nb;

   life_sequencer #(.GEN_TICKS(GT), .INIT_BOARD(INIT)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .load_valid(load_valid),
      .load_board(load_board), .cell_next(cell_next), .board(board),
      .read_cell_row(read_cell_row), .read_cell_col(read_cell_col), .curr_cell(curr_cell),
      .write_board_state(write_board_state), .busy(busy), .gen_done(gen_done),
      .generation(generation), .stable(stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Whole-board next generation, non-wrapping edges (cells off the board are dead).
   function automatic logic [63:0] life_next(input logic [63:0] b);
      logic [63:0] nb;
      int n;
      nb = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                      (c + dc) >= 0 && (c + dc) < 8) begin
                     n += int'(b[(r + dr) * 8 + (c + dc)]);
                  end
               end
            end
            nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
         end
      end
      return nb;
   endfunction

   // Engine stand-in: answers for whichever cell is addressed this cycle.
   always_comb begin
      eng_nb    = life_next(board);
      cell_next = eng_nb[{read_cell_row, read_cell_col}];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic load(input logic [63:0] b);
      load_board = b;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      exp_board  = b;
      exp_gen    = 16'd0;
      check("load_board", board, b);
      check("load_gen", 64'(generation), 64'(exp_gen));
   endtask

   // One stepped generation from IDLE, checking every scan cycle and the commit.
   task automatic step_gen();
      logic [63:0] cur;
      logic [5:0]  a;
      cur  = exp_board;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int k = 0; k < 64; k++) begin
         a = 6'(k);
         check("scan_ctrl", 64'({busy, write_board_state, gen_done, read_cell_row, read_cell_col, curr_cell}),
               64'({1'b1, 1'b1, 1'b0, a[5:3], a[2:0], cur[k]}));
         check("scan_board_held", board, cur);
         @(negedge clk);
      end
      check("commit_ctrl", 64'({busy, write_board_state, gen_done}), 64'(3'b101));
      @(negedge clk);
      exp_board = life_next(cur);
      exp_gen   = exp_gen + 16'd1;
      check("gen_board", board, exp_board);
      check("gen_count", 64'(generation), 64'(exp_gen));
      check("gen_idle", 64'({busy, gen_done, read_cell_row, read_cell_col}), 64'(0));
   endtask

   task automatic wait_done(input int bound, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!gen_done && cnt < bound);
   endtask

   initial begin
      int cnt;
      int busy_cnt;
      int done_cnt;
      logic [63:0] prev;
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      run        = 1'b0;
      step       = 1'b0;
      load_valid = 1'b0;
      load_board = '0;
      exp_board  = INIT;
      exp_gen    = 16'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_board", board, INIT);
      check("rst_gen", 64'(generation), 64'(0));
      check("rst_stable", 64'(stable), 64'(0));
      for (int i = 0; i < 100; i++) begin
         check("idle_quiet", 64'({busy, gen_done, write_board_state, read_cell_row, read_cell_col, curr_cell}),
               64'({9'd0, INIT[0]}));
         @(negedge clk);
      end
      check("idle_board", board, INIT);

      // Blinker, stepped twice: 0x0700 -> 0x020202 -> 0x0700
      load(64'h0000_0000_0000_0700);
      step_gen();
      check("blinker_vert", board, 64'h0000_0000_0002_0202);
      step_gen();

      for (int i = 0; i < 4; i++) begin
         load({$urandom, $urandom});
         step_gen();
      end

      // Auto-advance: counting resumes on the negedge after each board check, so every
      // wait covers GT idle + 64 scan cycles before gen_done appears.
      load(64'h0000_0000_0000_0700);
      run = 1'b1;
      for (int g = 0; g < 3; g++) begin
         prev = exp_board;
         wait_done(300, cnt);
         check("run_period", 64'(cnt), 64'(GT + 64));
         @(negedge clk);
         exp_board = life_next(prev);
         exp_gen   = exp_gen + 16'd1;
         check("run_board", board, exp_board);
         check("run_gen", 64'(generation), 64'(exp_gen));
      end
      run = 1'b0;
      repeat (2) @(negedge clk);

      // Load during a scan aborts it.
      load(64'h0000_0000_0000_0700);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_mid_scan", 64'(busy), 64'(1));
      load(64'h0000_0000_0000_FFFF);
      check("abort_idle", 64'(busy), 64'(0));
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         done_cnt += int'(gen_done);
         busy_cnt += int'(busy);
         @(negedge clk);
      end
      check("abort_no_done", 64'(done_cnt + busy_cnt), 64'(0));
      check("abort_board", board, 64'h0000_0000_0000_FFFF);

      // Load and step together: the load wins, no scan.
      load_board = 64'h0000_0000_0000_0303;
      load_valid = 1'b1;
      step       = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      step       = 1'b0;
      exp_board  = 64'h0000_0000_0000_0303;
      check("ldstep_board", board, exp_board);
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         busy_cnt += int'(busy);
         @(negedge clk);
      end
      check("ldstep_no_scan", 64'(busy_cnt), 64'(0));

      // Reset in the middle of a scan.
      load(64'h0000_0000_0000_0700);
      step_gen();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_board = INIT;
      exp_gen   = 16'd0;
      check("midrst_board", board, INIT);
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_gen", 64'(generation), 64'(0));
      step_gen();

      // Still life (block) under auto-advance.
      load(64'h0000_0000_0000_0303);
      run = 1'b1;
      wait_done(300, cnt);
      check("block_period", 64'(cnt), 64'(GT + 64));
      @(negedge clk);
      exp_gen = exp_gen + 16'd1;
      check("block_board", board, exp_board);
      check("block_stable", 64'(stable), 64'(STAB));
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         busy_cnt += int'(busy);
         done_cnt += int'(gen_done);
         @(negedge clk);
      end
      check("block_scans_seen", 64'(busy_cnt != 0), 64'(!STAB));
      run = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         done_cnt += int'(gen_done);
         @(negedge clk);
         cnt++;
      end
      check("block_settle", 64'(busy), 64'(0));
      exp_gen = exp_gen + 16'(done_cnt);
      check("block_gen", 64'(generation), 64'(exp_gen));
      step_gen();
      check("block_step_stable", 64'(stable), 64'(STAB));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
